// File: rtl/zx_kbd_port.sv
// ULA port 0xFE keyboard: stretches presses over FRAME_HOLD frames; read data 1 cycle after io_rd, no backpressure.
// Define KBD_GHOST_EN to add one registered step of matrix ghosting ahead of the column AND.
module zx_kbd_port #(
  parameter int FRAME_HOLD = 2,
  parameter int HOLD_W     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] key_0,
  input  logic [4:0] key_1,
  input  logic [4:0] key_2,
  input  logic [4:0] key_3,
  input  logic [4:0] key_4,
  input  logic [4:0] key_5,
  input  logic [4:0] key_6,
  input  logic [4:0] key_7,
  input  logic       frame_int,
  input  logic       io_rd,
  input  logic [7:0] addr_hi,
  input  logic       ear_in,
  output logic [7:0] kbd_data,
  output logic       kbd_valid,
  output logic       any_key
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FRAME_HOLD);
  localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);

  logic [4:0]        key_in  [8];
  logic [4:0]        key_q   [8];
  logic [4:0]        latched [8];
  logic [HOLD_W-1:0] cnt     [8];
  logic [4:0]        eff     [8];
  logic [4:0]        src     [8];
  logic [4:0]        cols;
  logic [4:0]        all_eff;

  assign key_in[0] = key_0;
  assign key_in[1] = key_1;
  assign key_in[2] = key_2;
  assign key_in[3] = key_3;
  assign key_in[4] = key_4;
  assign key_in[5] = key_5;
  assign key_in[6] = key_6;
  assign key_in[7] = key_7;

  // A key reads pressed while physically held or while its row stretch runs.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      eff[r] = key_q[r] & latched[r];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 8; r++) begin
        key_q[r]   <= 5'h1F;
        latched[r] <= 5'h1F;
        cnt[r]     <= '0;
      end
    end else begin
      for (int r = 0; r < 8; r++) begin
        key_q[r] <= key_in[r];
        // A fresh press restarts the stretch even if a frame tick lands on the same cycle.
        if ((key_q[r] & ~key_in[r]) != 5'h00) begin
          latched[r] <= latched[r] & key_in[r];
          cnt[r]     <= HOLD_INIT;
        end else if (frame_int && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_ONE;
          if (cnt[r] == CNT_ONE) begin
            latched[r] <= 5'h1F;
          end
        end
      end
    end
  end

`ifdef KBD_GHOST_EN
  logic [4:0] ghost   [8];
  logic [4:0] ghost_d [8];

  // Rows sharing a pressed column short together, pulling in each other's pressed columns.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      ghost_d[r] = eff[r];
      for (int s = 0; s < 8; s++) begin
        if ((~eff[r] & ~eff[s]) != 5'h00) begin
          ghost_d[r] = ghost_d[r] & eff[s];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 8; r++) begin
        ghost[r] <= 5'h1F;
      end
    end else begin
      for (int r = 0; r < 8; r++) begin
        ghost[r] <= ghost_d[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      src[r] = ghost[r];
    end
  end
`else
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      src[r] = eff[r];
    end
  end
`endif

  always_comb begin
    cols    = 5'h1F;
    all_eff = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!addr_hi[r]) begin
        cols = cols & src[r];
      end
      all_eff = all_eff & eff[r];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kbd_data  <= 8'hFF;
      kbd_valid <= 1'b0;
      any_key   <= 1'b0;
    end else begin
      if (io_rd) begin
        kbd_data <= {1'b1, ear_in, 1'b1, cols};
      end
      kbd_valid <= io_rd;
      any_key   <= (all_eff != 5'h1F);
    end
  end

endmodule

// File: tb/tb_zx_kbd_port.sv
// Bench for zx_kbd_port: per-key behavioural model checked every cycle, plus directed literal scenarios.
module tb_zx_kbd_port;

  localparam int FRAME_HOLD = 2;
`ifdef KBD_GHOST_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] keys [8];
  logic       frame_int = 1'b0;
  logic       io_rd = 1'b0;
  logic [7:0] addr_hi = 8'hFF;
  logic       ear_in = 1'b0;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       any_key;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zx_kbd_port #(.FRAME_HOLD(FRAME_HOLD), .HOLD_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .key_0(keys[0]), .key_1(keys[1]), .key_2(keys[2]), .key_3(keys[3]),
    .key_4(keys[4]), .key_5(keys[5]), .key_6(keys[6]), .key_7(keys[7]),
    .frame_int(frame_int), .io_rd(io_rd), .addr_hi(addr_hi), .ear_in(ear_in),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .any_key(any_key)
  );

  // Model state per key: held = pressed at last edge, strc = kept visible by row stretch.
  bit         held [8][5];
  bit         strc [8][5];
  bit         gh   [8][5];
  bit         e    [8][5];
  bit         g    [8][5];
  int         left [8];
  logic [7:0] exp_data = 8'hFF;
  bit         exp_valid = 1'b0;
  bit         exp_any = 1'b0;
  logic [4:0] mcols;
  bit         newp;
  bit         share;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 5; c++) begin
          held[r][c] = 1'b0;
          strc[r][c] = 1'b0;
          gh[r][c]   = 1'b0;
        end
        left[r] = 0;
      end
      exp_data  = 8'hFF;
      exp_valid = 1'b0;
      exp_any   = 1'b0;
    end else begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 5; c++)
          e[r][c] = held[r][c] | strc[r][c];
      exp_valid = io_rd;
      if (io_rd) begin
        mcols = 5'h1F;
        for (int r = 0; r < 8; r++)
          if (addr_hi[r] == 1'b0)
            for (int c = 0; c < 5; c++)
              if (GHOST ? gh[r][c] : e[r][c]) mcols[c] = 1'b0;
        exp_data = {1'b1, ear_in, 1'b1, mcols};
      end
      exp_any = 1'b0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 5; c++)
          if (e[r][c]) exp_any = 1'b1;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 5; c++) begin
          g[r][c] = e[r][c];
          for (int s = 0; s < 8; s++) begin
            share = 1'b0;
            for (int c2 = 0; c2 < 5; c2++)
              if (e[r][c2] && e[s][c2]) share = 1'b1;
            if (share && e[s][c]) g[r][c] = 1'b1;
          end
        end
      end
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 5; c++)
          gh[r][c] = g[r][c];
      for (int r = 0; r < 8; r++) begin
        newp = 1'b0;
        for (int c = 0; c < 5; c++)
          if (!held[r][c] && keys[r][c] == 1'b0) newp = 1'b1;
        if (newp) begin
          for (int c = 0; c < 5; c++)
            if (keys[r][c] == 1'b0) strc[r][c] = 1'b1;
          left[r] = FRAME_HOLD;
        end else if (frame_int && left[r] > 0) begin
          left[r] = left[r] - 1;
          if (left[r] == 0)
            for (int c = 0; c < 5; c++) strc[r][c] = 1'b0;
        end
      end
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 5; c++)
          held[r][c] = (keys[r][c] == 1'b0);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("cyc_valid", {7'b0, kbd_valid}, {7'b0, exp_valid});
    chk("cyc_data", kbd_data, exp_data);
    chk("cyc_any", {7'b0, any_key}, {7'b0, exp_any});
  endtask

  task automatic rd(input logic [7:0] a, input logic ear);
    tick();
    io_rd   = 1'b1;
    addr_hi = a;
    ear_in  = ear;
    tick();
    io_rd   = 1'b0;
    addr_hi = 8'hFF;
  endtask

  task automatic frame();
    frame_int = 1'b1;
    tick();
    frame_int = 1'b0;
  endtask

  logic [4:0] v;
  logic [7:0] a;

  initial begin
    for (int r = 0; r < 8; r++) keys[r] = 5'h1F;
    tick();
    tick();

    // T1: reset swallows a simultaneous read
    io_rd = 1'b1; addr_hi = 8'h00;
    tick();
    chk("t1_rst_data", kbd_data, 8'hFF);
    chk("t1_rst_valid", {7'b0, kbd_valid}, 8'h00);
    chk("t1_rst_any", {7'b0, any_key}, 8'h00);
    reset_n = 1'b1; io_rd = 1'b0; addr_hi = 8'hFF;
    rd(8'h00, 1'b0);
    chk("t1_idle_read", kbd_data, 8'hBF);
    chk("t1_idle_valid", {7'b0, kbd_valid}, 8'h01);

    // T2: basic read of row 1
    keys[1] = 5'h1E;
    tick();
    rd(8'hFD, 1'b0);
    chk("t2_data", kbd_data, 8'hBE);
    chk("t2_valid", {7'b0, kbd_valid}, 8'h01);
    chk("t2_any", {7'b0, any_key}, 8'h01);
    tick();
    chk("t2_valid_drop", {7'b0, kbd_valid}, 8'h00);
    chk("t2_data_hold", kbd_data, 8'hBE);
    keys[1] = 5'h1F;
    frame(); frame(); tick();
    chk("t2_any_clear", {7'b0, any_key}, 8'h00);

    // T3: one-cycle press stretched over two frames; coincident read sees pre-update state
    keys[7] = 5'h1B;
    tick();
    keys[7] = 5'h1F;
    tick();
    rd(8'h7F, 1'b0);
    chk("t3_stretch0", kbd_data, 8'hBB);
    frame();
    rd(8'h7F, 1'b0);
    chk("t3_stretch1", kbd_data, 8'hBB);
    io_rd = 1'b1; addr_hi = 8'h7F; frame_int = 1'b1;
    tick();
    io_rd = 1'b0; addr_hi = 8'hFF; frame_int = 1'b0;
    chk("t3_coincide", kbd_data, 8'hBB);
    rd(8'h7F, 1'b0);
    chk("t3_expired", kbd_data, 8'hBF);

    // T4: multi-row AND, and no row selected
    keys[0] = 5'h1E; keys[7] = 5'h1D;
    tick();
    rd(8'h7E, 1'b0);
    chk("t4_multi", kbd_data, 8'hBC);
    rd(8'hFF, 1'b0);
    chk("t4_none", kbd_data, 8'hBF);
    keys[0] = 5'h1F; keys[7] = 5'h1F;
    frame(); frame();

    // T5: new press wins over coincident frame tick
    keys[3] = 5'h1E;
    tick();
    keys[3] = 5'h1F;
    frame();
    keys[3] = 5'h1D; frame_int = 1'b1;
    tick();
    frame_int = 1'b0; keys[3] = 5'h1F;
    frame();
    rd(8'hF7, 1'b1);
    chk("t5_restart", kbd_data, 8'hFC);
    frame();
    rd(8'hF7, 1'b1);
    chk("t5_expired", kbd_data, 8'hFF);

    // T6: ghosting via row 1
    keys[0] = 5'h1E; keys[1] = 5'h1C; keys[2] = 5'h1D;
    tick();
    rd(8'hFE, 1'b0);
    chk("t6_ghost", kbd_data, GHOST ? 8'hBC : 8'hBE);
    keys[0] = 5'h1F; keys[1] = 5'h1F; keys[2] = 5'h1F;
    frame(); frame();

    // Reset in the middle of a stretch clears it
    keys[5] = 5'h1E;
    tick();
    keys[5] = 5'h1F;
    tick();
    reset_n = 1'b0; io_rd = 1'b1; addr_hi = 8'hDF;
    tick();
    chk("rst_mid_valid", {7'b0, kbd_valid}, 8'h00);
    chk("rst_mid_data", kbd_data, 8'hFF);
    reset_n = 1'b1; io_rd = 1'b0; addr_hi = 8'hFF;
    rd(8'hDF, 1'b0);
    chk("rst_mid_read", kbd_data, 8'hBF);

    // Back-to-back reads
    keys[2] = 5'h1B;
    tick(); tick();
    io_rd = 1'b1; addr_hi = 8'hFB;
    tick();
    chk("b2b_first", kbd_data, 8'hBB);
    addr_hi = 8'hFF;
    tick();
    chk("b2b_second", kbd_data, 8'hBF);
    chk("b2b_valid", {7'b0, kbd_valid}, 8'h01);
    io_rd = 1'b0;
    keys[2] = 5'h1F;
    frame(); frame();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      for (int r = 0; r < 8; r++) begin
        if ($urandom_range(0, 7) == 0) begin
          v = 5'h1F;
          if ($urandom_range(0, 1) == 1) v[$urandom_range(0, 4)] = 1'b0;
          if ($urandom_range(0, 5) == 0) v[$urandom_range(0, 4)] = 1'b0;
          keys[r] = v;
        end
      end
      frame_int = ($urandom_range(0, 5) == 0);
      io_rd     = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: a = 8'hFF;
        1: begin a = 8'hFF; a[$urandom_range(0, 7)] = 1'b0; end
        2: a = 8'($urandom);
        default: a = 8'h00;
      endcase
      addr_hi = a;
      ear_in  = 1'($urandom_range(0, 1));
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
